// File: rtl/class_argmax_irq.sv
// Argmax stage: latches the last-layer score vector, scans it serially for the largest
// signed score and publishes the winning index with a sticky interrupt.
// Optional runner-up index and margin outputs: define CLASS_ARGMAX_TOP2_EN.
module class_argmax_irq #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    input  logic                              intr_clr,
    output logic                              busy,
    output logic [IDX_WIDTH-1:0]              out_idx,
    output logic [DATA_WIDTH-1:0]             out_val,
    output logic                              out_valid,
    output logic                              intr,
    output logic                              overrun
`ifdef CLASS_ARGMAX_TOP2_EN
    ,
    output logic [IDX_WIDTH-1:0]              out_idx2,
    output logic [DATA_WIDTH:0]               out_margin
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t state_reg, state_next;

    logic signed [DATA_WIDTH-1:0] elem    [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] vec_reg [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] cur_val;
    logic signed [DATA_WIDTH-1:0] best_val_reg;
    logic [IDX_WIDTH-1:0]         best_idx_reg;
    logic [IDX_WIDTH-1:0]         cnt_reg;
    logic                         busy_reg;
    logic [IDX_WIDTH-1:0]         out_idx_reg;
    logic [DATA_WIDTH-1:0]        out_val_reg;
    logic                         out_valid_reg;
    logic                         intr_reg;
    logic                         overrun_reg;

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
            assign elem[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign cur_val = vec_reg[cnt_reg];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SCAN;
            SCAN:    if (cnt_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) vec_reg[k] <= '0;
            best_val_reg  <= '0;
            best_idx_reg  <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            out_idx_reg   <= '0;
            out_val_reg   <= '0;
            out_valid_reg <= 1'b0;
            intr_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++) vec_reg[k] <= elem[k];
                        best_val_reg <= elem[0];
                        best_idx_reg <= '0;
                        cnt_reg      <= IDX_WIDTH'(1);
                        busy_reg     <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strictly greater, so ties keep the lower index.
                    if (cur_val > best_val_reg) begin
                        best_val_reg <= cur_val;
                        best_idx_reg <= cnt_reg;
                    end
                    if (cnt_reg != LAST_IDX) cnt_reg <= cnt_reg + 1'b1;
                end
                DONE: begin
                    out_idx_reg   <= best_idx_reg;
                    out_val_reg   <= best_val_reg;
                    out_valid_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: ;
            endcase
            if (in_valid && state_reg != IDLE) overrun_reg <= 1'b1;
            // A result arriving together with a clear keeps the interrupt raised.
            if (state_reg == DONE) intr_reg <= 1'b1;
            else if (intr_clr)     intr_reg <= 1'b0;
        end
    end

    assign busy      = busy_reg;
    assign out_idx   = out_idx_reg;
    assign out_val   = out_val_reg;
    assign out_valid = out_valid_reg;
    assign intr      = intr_reg;
    assign overrun   = overrun_reg;

`ifdef CLASS_ARGMAX_TOP2_EN
    logic signed [DATA_WIDTH-1:0] best2_val_reg;
    logic [IDX_WIDTH-1:0]         best2_idx_reg;
    logic                         has2_reg;
    logic [IDX_WIDTH-1:0]         out_idx2_reg;
    logic [DATA_WIDTH:0]          out_margin_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            best2_val_reg  <= '0;
            best2_idx_reg  <= '0;
            has2_reg       <= 1'b0;
            out_idx2_reg   <= '0;
            out_margin_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) has2_reg <= 1'b0;
                SCAN: begin
                    // A displaced leader becomes the runner-up; equal scores fall here.
                    if (cur_val > best_val_reg) begin
                        best2_val_reg <= best_val_reg;
                        best2_idx_reg <= best_idx_reg;
                    end else if (!has2_reg || cur_val > best2_val_reg) begin
                        best2_val_reg <= cur_val;
                        best2_idx_reg <= cnt_reg;
                    end
                    has2_reg <= 1'b1;
                end
                DONE: begin
                    out_idx2_reg   <= best2_idx_reg;
                    out_margin_reg <= {best_val_reg[DATA_WIDTH-1], best_val_reg}
                                    - {best2_val_reg[DATA_WIDTH-1], best2_val_reg};
                end
                default: ;
            endcase
        end
    end

    assign out_idx2   = out_idx2_reg;
    assign out_margin = out_margin_reg;
`endif

endmodule
